// File: rtl/shift_rgst_pkg.sv
// Shared types for the shift_rgst block: shift-mode encoding, FSM states and
// the vacated-bit selection helper used by the datapath.
package shift_rgst_pkg;

  typedef enum logic [1:0] {
    MODE_LOG = 2'b00,
    MODE_ARI = 2'b01,
    MODE_ROT = 2'b10,
    MODE_SER = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Bit entering the vacated position for one shift step.
  // Arithmetic left behaves as logical left; only arithmetic right copies the MSB.
  function automatic logic fill_bit(input mode_e mode, input logic dir,
                                    input logic msb, input logic out_bit,
                                    input logic sin);
    logic res;
    res = 1'b0;
    case (mode)
      MODE_LOG: res = 1'b0;
      MODE_ARI: res = dir ? msb : 1'b0;
      MODE_ROT: res = out_bit;
      MODE_SER: res = sin;
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/shift_rgst_ctl.sv
// Control for shift_rgst: IDLE/SHIFT/DONE state machine and step counter.
// Decides when a load is allowed, when a start is accepted and when the
// datapath takes a shift step. The requested amount is converted here into
// the real number of steps (saturated to W, or modulo W for rotate).
module shift_rgst_ctl
  import shift_rgst_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clr,
  input  logic          ld,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] amt,
  output logic          busy,
  output logic          done,
  output logic          accept,
  output logic          load_en,
  output logic          step
);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_W    = CW'(W);
  localparam logic [31:0]   W_U      = 32'(W);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] eff_cnt_s;
  logic [31:0]   amt_ext_s;
  logic          idle_like_s;

  assign amt_ext_s   = 32'(amt);
  assign idle_like_s = (state_q == IDLE) || (state_q == DONE);

  // clr beats ld beats start; nothing new is taken while a shift is running
  assign load_en = ld && !clr && idle_like_s;
  assign accept  = start && !ld && !clr && idle_like_s;
  assign step    = (state_q == SHIFT) && !clr;
  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);

  // Number of steps an accepted start will run: rotate wraps, others saturate at W
  always_comb begin
    eff_cnt_s = amt;
    if (mode_e'(mode) == MODE_ROT) begin
      eff_cnt_s = CW'(amt_ext_s % W_U);
    end else if (amt > CNT_W) begin
      eff_cnt_s = CNT_W;
    end else begin
      eff_cnt_s = amt;
    end
  end

  // Next state and step counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (eff_cnt_s == CNT_ZERO) begin
              state_d = DONE;
              cnt_d   = CNT_ZERO;
            end else begin
              state_d = SHIFT;
              cnt_d   = eff_cnt_s;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end
        end
        SHIFT: begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_rgst.sv
// shift_rgst: W-bit shift register with parallel load and a multi-cycle
// shift operation (logical, arithmetic, rotate, serial-in), one position
// per clock. Control lives in shift_rgst_ctl; the datapath is here.
// Optional feature: define SHIFT_RGST_CARRY_EN to get a cout register that
// captures the last bit shifted out; otherwise cout is tied low.
module shift_rgst
  import shift_rgst_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clr,
  input  logic          ld,
  input  logic [W-1:0]  d,
  input  logic          start,
  input  logic          dir,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] amt,
  input  logic          sin,
  output logic [W-1:0]  q,
  output logic          busy,
  output logic          done,
  output logic          sout,
  output logic          cout
);

  logic         busy_s, done_s, accept_s, load_en_s, step_s;
  logic [W-1:0] q_q, q_d;
  mode_e        mode_q, mode_d;
  logic         dir_q, dir_d;
  logic         out_bit_s, fill_s;
  logic [W-1:0] shifted_s;

  shift_rgst_ctl #(
    .W  (W),
    .CW (CW)
  ) u_ctl (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr     (clr),
    .ld      (ld),
    .start   (start),
    .mode    (mode),
    .amt     (amt),
    .busy    (busy_s),
    .done    (done_s),
    .accept  (accept_s),
    .load_en (load_en_s),
    .step    (step_s)
  );

  // One-position shift of the current contents using the latched mode/direction
  always_comb begin
    out_bit_s = dir_q ? q_q[0] : q_q[W-1];
    fill_s    = fill_bit(mode_q, dir_q, q_q[W-1], out_bit_s, sin);
    if (dir_q) begin
      shifted_s = {fill_s, q_q[W-1:1]};
    end else begin
      shifted_s = {q_q[W-2:0], fill_s};
    end
  end

  // Next register contents and operation latch (mode/dir frozen at start)
  always_comb begin
    q_d    = q_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    if (clr) begin
      q_d = {W{1'b0}};
    end else if (load_en_s) begin
      q_d = d;
    end else if (step_s) begin
      q_d = shifted_s;
    end else begin
      q_d = q_q;
    end
    if (accept_s) begin
      mode_d = mode_e'(mode);
      dir_d  = dir;
    end else begin
      mode_d = mode_q;
      dir_d  = dir_q;
    end
  end

  // Datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      q_q    <= {W{1'b0}};
      mode_q <= MODE_LOG;
      dir_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
    end
  end

  assign q    = q_q;
  assign busy = busy_s;
  assign done = done_s;
  // Outgoing bit is only meaningful while a shift is in progress
  assign sout = busy_s ? out_bit_s : 1'b0;

`ifdef SHIFT_RGST_CARRY_EN
  logic cout_q, cout_d;

  // Carry follows the outgoing bit on every step, holds otherwise
  always_comb begin
    cout_d = cout_q;
    if (clr) begin
      cout_d = 1'b0;
    end else if (step_s) begin
      cout_d = out_bit_s;
    end else begin
      cout_d = cout_q;
    end
  end

  // Carry register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cout_q <= 1'b0;
    end else begin
      cout_q <= cout_d;
    end
  end

  assign cout = cout_q;
`else
  assign cout = 1'b0;
`endif

endmodule

// File: tb/tb_shift_rgst.sv
// Scoreboard bench for shift_rgst (W=8). Stimulus pushes expected results
// (final q, cout, busy-cycle count) and expected sout per shift step; a
// monitor on the falling edge pops and compares whenever busy/done appear.
module tb_shift_rgst;

`ifdef SHIFT_RGST_CARRY_EN
  localparam logic CARRY = 1'b1;
`else
  localparam logic CARRY = 1'b0;
`endif

  logic       clk, rst_b, clr, ld, start, dir, sin;
  logic [7:0] d;
  logic [1:0] mode;
  logic [3:0] amt;
  logic [7:0] q;
  logic       busy, done, sout, cout;

  typedef struct {
    logic [7:0] q;
    logic       cout;
    int         busy;
  } exp_t;

  exp_t exp_q[$];
  logic sout_exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   busy_run = 0;

  shift_rgst #(.W(8), .CW(4)) dut (
    .clk(clk), .rst_b(rst_b), .clr(clr), .ld(ld), .d(d), .start(start),
    .dir(dir), .mode(mode), .amt(amt), .sin(sin), .q(q), .busy(busy),
    .done(done), .sout(sout), .cout(cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: unexpected DUT event", name);
  endtask

  // Monitor: per-step sout check and end-of-operation scoreboard compare
  always @(negedge clk) begin
    exp_t e;
    if (busy) begin
      if (sout_exp_q.size() == 0) fail("sout_step_extra");
      else chk("sout_step", 32'(sout), 32'(sout_exp_q.pop_front()));
    end else begin
      chk("sout_idle", 32'(sout), 32'd0);
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        fail("spurious_done");
      end else begin
        e = exp_q.pop_front();
        chk("done_q", 32'(q), 32'(e.q));
        chk("done_cout", 32'(cout), 32'(e.cout));
        chk("busy_cycles", 32'(busy_run), 32'(e.busy));
      end
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  task automatic do_ld(input logic [7:0] v);
    ld = 1'b1;
    d  = v;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // Issue a one-cycle start, then scramble the operation inputs
  task automatic start_op(input logic di, input logic [1:0] mo, input logic [3:0] am);
    start = 1'b1;
    dir   = di;
    mode  = mo;
    amt   = am;
    @(negedge clk);
    start = 1'b0;
    dir   = ~di;
    mode  = mo ^ 2'b01;
    amt   = am ^ 4'b0101;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(name, 32'(seen), 32'd1);
    @(negedge clk);
  endtask

  task automatic push_sout(input logic b, input int n);
    for (int i = 0; i < n; i++) sout_exp_q.push_back(b);
  endtask

  initial begin
    rst_b = 1'b0; clr = 1'b0; ld = 1'b0; start = 1'b0; dir = 1'b0;
    sin = 1'b0; d = 8'h00; mode = 2'b00; amt = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sout", 32'(sout), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst_b = 1'b1;
    @(negedge clk);

    // arithmetic right 3 of B4 -> F6
    do_ld(8'hB4);
    exp_q.push_back('{q: 8'hF6, cout: CARRY, busy: 3});
    sout_exp_q.push_back(1'b0); sout_exp_q.push_back(1'b0); sout_exp_q.push_back(1'b1);
    start_op(1'b1, 2'b01, 4'd3);
    wait_done("to_ari_r3");

    // rotate left amt 9 -> one step
    do_ld(8'h81);
    exp_q.push_back('{q: 8'h03, cout: CARRY, busy: 1});
    sout_exp_q.push_back(1'b1);
    start_op(1'b0, 2'b10, 4'd9);
    wait_done("to_rot9");

    // rotate left amt 8 -> no steps, cout holds
    do_ld(8'h81);
    exp_q.push_back('{q: 8'h81, cout: CARRY, busy: 0});
    start_op(1'b0, 2'b10, 4'd8);
    wait_done("to_rot8");

    // serial-in left, sin 1,0,1,1 -> 0B
    do_ld(8'h00);
    exp_q.push_back('{q: 8'h0B, cout: 1'b0, busy: 4});
    push_sout(1'b0, 4);
    start_op(1'b0, 2'b11, 4'd4);
    sin = 1'b1; @(negedge clk);
    sin = 1'b0; @(negedge clk);
    sin = 1'b1; @(negedge clk);
    sin = 1'b1;
    wait_done("to_ser4");
    sin = 1'b0;

    // clr on second busy cycle aborts
    do_ld(8'hC3);
    push_sout(1'b1, 2);
    start_op(1'b0, 2'b00, 4'd5);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_q", 32'(q), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    chk("clr_cout", 32'(cout), 32'd0);
    repeat (3) @(negedge clk);

    // rotate right 6 with ld + start during SHIFT ignored
    do_ld(8'h96);
    exp_q.push_back('{q: 8'h5A, cout: 1'b0, busy: 6});
    sout_exp_q.push_back(1'b0); sout_exp_q.push_back(1'b1); sout_exp_q.push_back(1'b1);
    sout_exp_q.push_back(1'b0); sout_exp_q.push_back(1'b1); sout_exp_q.push_back(1'b0);
    start_op(1'b1, 2'b10, 4'd6);
    @(negedge clk);
    ld = 1'b1; d = 8'hFF; start = 1'b1; mode = 2'b00; amt = 4'd1; dir = 1'b0;
    @(negedge clk);
    ld = 1'b0; start = 1'b0;
    wait_done("to_rot_r6");
    repeat (2) @(negedge clk);

    // reset in the middle of a shift
    do_ld(8'hFF);
    push_sout(1'b1, 2);
    start_op(1'b1, 2'b00, 4'd5);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    chk("mrst_q", 32'(q), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_sout", 32'(sout), 32'd0);
    chk("mrst_cout", 32'(cout), 32'd0);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // amt 0: q unchanged, done next cycle
    do_ld(8'h3C);
    exp_q.push_back('{q: 8'h3C, cout: 1'b0, busy: 0});
    start_op(1'b0, 2'b00, 4'd0);
    wait_done("to_amt0");

    // logical right amt 15 saturates to 8
    do_ld(8'hFF);
    exp_q.push_back('{q: 8'h00, cout: CARRY, busy: 8});
    push_sout(1'b1, 8);
    start_op(1'b1, 2'b00, 4'd15);
    wait_done("to_sat");

    // arithmetic left behaves as logical left
    do_ld(8'h4D);
    exp_q.push_back('{q: 8'h34, cout: CARRY, busy: 2});
    sout_exp_q.push_back(1'b0); sout_exp_q.push_back(1'b1);
    start_op(1'b0, 2'b01, 4'd2);
    wait_done("to_ari_l2");

    // ld and start together: load wins, no operation
    ld = 1'b1; d = 8'h55; start = 1'b1; amt = 4'd3; mode = 2'b00; dir = 1'b0;
    @(negedge clk);
    ld = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("ldprio_q", 32'(q), 32'h55);
    chk("ldprio_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("sout_sb_empty", 32'(sout_exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_rgst.md
SHIFT_RGST -- requirements
Module: shift_rgst

Interface
REQ-001 Parameter W, default 8: register width, W >= 2.
REQ-002 Parameter CW, default $clog2(W)+1: width of shift-amount port.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_b  input  1  reset, synchronous, active-low.
REQ-005 clr  input  1  synchronous clear of q, aborts any shift in progress.
REQ-006 ld  input  1  parallel load of d into q.
REQ-007 d  input  W  parallel load data.
REQ-008 start  input  1  begin multi-cycle shift operation.
REQ-009 dir  input  1  shift direction: 0 left (toward MSB), 1 right.
REQ-010 mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 serial-in.
REQ-011 amt  input  CW  number of bit positions to shift.
REQ-012 sin  input  1  serial input bit, used in mode 11.
REQ-013 q  output  W  register contents.
REQ-014 busy  output  1  high while shifting.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 sout  output  1  bit leaving the register on the current shift step, else 0.
REQ-017 cout  output  1  last bit shifted out (see Configuration).

Function
REQ-018 FSM states IDLE, SHIFT, DONE; busy SHALL be high exactly in SHIFT, done exactly in DONE.
REQ-019 Priority each edge: rst_b low > clr > ld > start.
REQ-020 clr in any state: q <= 0, state <= IDLE, counter <= 0, no done pulse.
REQ-021 ld SHALL act only in IDLE or DONE (q <= d); ld during SHIFT is ignored.
REQ-022 start SHALL be accepted only in IDLE or DONE with clr and ld low; ignored during SHIFT.
REQ-023 mode, dir, amt, sin-usage SHALL be latched at start; later input changes do not affect the operation, except sin, sampled every step.
REQ-024 On accepted start with amt=0: q unchanged, next state DONE (done one cycle later).
REQ-025 On accepted start with amt=k>0: counter <= min(k,W); q shifts one position per cycle on the k following edges; DONE entered on the edge of the last shift; done high the next cycle, then IDLE.
REQ-026 amt > W SHALL saturate to W; in rotate mode saturation SHALL NOT apply (count taken modulo W, count 0 -> behaves as amt=0).
REQ-027 Logical: vacated bit 0. Arithmetic right: vacated bit = q[W-1]; arithmetic left = logical left.
REQ-028 Rotate: vacated bit = bit shifted out. Serial-in: vacated bit = sin.
REQ-029 sout SHALL equal q[W-1] (left) or q[0] (right) during SHIFT, 0 otherwise.

Reset
REQ-030 On rising clk with rst_b low: q=0, state IDLE, counter=0, busy=0, done=0, sout=0, cout=0.
REQ-031 Reset asserted during SHIFT SHALL abort with no done pulse.

Configuration
REQ-032 Macro SHIFT_RGST_CARRY_EN defined: cout is a register updated with sout on every shift step, holds value otherwise, cleared by clr and reset.
REQ-033 Macro undefined: cout tied to 0, no carry register synthesised.

Structure
REQ-034 Package shift_rgst_pkg SHALL hold the mode encoding typedef (MODE_LOG, MODE_ARI, MODE_ROT, MODE_SER) and the FSM state typedef.
REQ-035 Sub-module shift_rgst_ctl SHALL contain FSM and step counter; datapath stays in shift_rgst.

Verification
REQ-036 W=8, ld d=8'hB4, start dir=1 mode=01 amt=3 -> busy 3 cycles, q=8'hF6, done one cycle, cout=1 (macro on).
REQ-037 ld 8'h81, start dir=0 mode=10 amt=9 -> 1 shift cycle, q=8'h03; amt=8 -> q=8'h81 after immediate done.
REQ-038 ld 8'h00, mode=11 dir=0 amt=4, sin=1,0,1,1 per step -> q=8'h0B, sout all 0.
REQ-039 Start amt=5, clr asserted on 2nd busy cycle -> q=0, busy=0 next cycle, no done pulse.
REQ-040 Start amt=6, ld and second start during SHIFT -> both ignored, original result and single done; rst_b low mid-shift -> all outputs 0 next edge.
